// File: rtl/room_sequencer.sv
// room_sequencer: title -> start blink -> play -> pause/game-over flow owning RoomNum, logo_en, freeze, lives.
// Define ROOM_SEQ_LIVES_EN to enable life counting and GAME_OVER; otherwise lives is tied to START_LIVES.
module room_sequencer #(
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_HALF   = 8,
  parameter int PAUSE_FRAMES = 90,
  parameter int START_LIVES  = 3,
  parameter int LAST_ROOM    = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       mario_dead,
  input  logic       level_clear,
  output logic [1:0] RoomNum,
  output logic       logo_en,
  output logic       freeze,
  output logic [1:0] lives
);
  typedef enum logic [2:0] {TITLE, START_BLINK, PLAY, DEATH_PAUSE, CLEAR_PAUSE, GAME_OVER} state_t;
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);
  localparam logic [7:0] HALF       = 8'(BLINK_HALF);
  localparam logic [1:0] LIVES0     = 2'(START_LIVES);
  localparam logic [1:0] LAST       = 2'(LAST_ROOM);
  state_t state, state_n;
  logic frame_clk_q, start_key_q, start_arm, frame_tick, start_edge, expire;
  logic [7:0] fcnt, fcnt_n, half_idx;
  logic [1:0] room, room_n, room_out;
  logic logo_n, freeze_n;
`ifdef ROOM_SEQ_LIVES_EN
  logic [1:0] lives_q, lives_n;
  assign lives = lives_q;
  always_ff @(posedge Clk)
    if (Reset) lives_q <= '0;
    else lives_q <= lives_n;
`else
  assign lives = LIVES0;
`endif
  assign expire = frame_tick && fcnt == PAUSE_LAST;
  always_comb begin
    state_n = state;
    room_n  = room;
`ifdef ROOM_SEQ_LIVES_EN
    lives_n = lives_q;
`endif
    case (state)
      TITLE: if (start_edge) begin
        state_n = START_BLINK;
`ifdef ROOM_SEQ_LIVES_EN
        lives_n = LIVES0;
`endif
      end
      START_BLINK: if (frame_tick && fcnt == BLINK_LAST) begin
        state_n = PLAY;
        room_n  = 2'd1;
      end
      PLAY: state_n = mario_dead ? DEATH_PAUSE : level_clear ? CLEAR_PAUSE : PLAY;
      DEATH_PAUSE: if (expire) begin
`ifdef ROOM_SEQ_LIVES_EN
        state_n = (lives_q == 2'd1) ? GAME_OVER : PLAY;
        lives_n = (lives_q == 2'd1) ? 2'd0 : lives_q - 2'd1;
`else
        state_n = PLAY;
`endif
      end
      CLEAR_PAUSE: if (expire) begin
        state_n = (room >= LAST) ? TITLE : PLAY;
        room_n  = (room >= LAST) ? 2'd0 : room + 2'd1;
      end
      GAME_OVER: if (expire) state_n = TITLE;
      default: state_n = TITLE;
    endcase
    fcnt_n   = (state_n != state) ? 8'd0 : (frame_tick && fcnt != 8'hff) ? fcnt + 8'd1 : fcnt;
    half_idx = fcnt_n / HALF;
    room_out = (state_n == PLAY || state_n == DEATH_PAUSE || state_n == CLEAR_PAUSE) ? room_n : 2'd0;
    logo_n   = (state_n == TITLE) || (state_n == START_BLINK && !half_idx[0]);
    freeze_n = state_n != PLAY;
  end
  // start_arm blocks a key held across reset release from looking like a fresh press
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= TITLE;
      frame_clk_q <= 1'b0;
      start_key_q <= 1'b0;
      start_arm   <= 1'b0;
      frame_tick  <= 1'b0;
      start_edge  <= 1'b0;
      fcnt        <= '0;
      room        <= '0;
      RoomNum     <= '0;
      logo_en     <= 1'b1;
      freeze      <= 1'b1;
    end else begin
      state       <= state_n;
      frame_clk_q <= frame_clk;
      start_key_q <= start_key;
      start_arm   <= start_arm | ~start_key;
      frame_tick  <= frame_clk & ~frame_clk_q;
      start_edge  <= start_key & ~start_key_q & start_arm;
      fcnt        <= fcnt_n;
      room        <= room_n;
      RoomNum     <= room_out;
      logo_en     <= logo_n;
      freeze      <= freeze_n;
    end
  end
endmodule

// File: tb/tb_room_sequencer.sv
// tb_room_sequencer: directed plus randomized game-flow checks against a game-level model of rooms and lives.
module tb_room_sequencer;
  logic Clk = 0, Reset = 1, frame_clk = 0, start_key = 0, mario_dead = 0, level_clear = 0;
  logic [1:0] RoomNum, lives;
  logic logo_en, freeze;
  int errors = 0, checks = 0;
  int m_room, m_lives;
`ifdef ROOM_SEQ_LIVES_EN
  localparam bit LV = 1;
`else
  localparam bit LV = 0;
`endif
  localparam int SL = 2;
  localparam int RST_LIVES = LV ? 0 : SL;

  room_sequencer #(.BLINK_FRAMES(4), .BLINK_HALF(2), .PAUSE_FRAMES(3), .START_LIVES(SL), .LAST_ROOM(2)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start_key(start_key),
    .mario_dead(mario_dead), .level_clear(level_clear),
    .RoomNum(RoomNum), .logo_en(logo_en), .freeze(freeze), .lives(lives)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $error("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int room, input int logo, input int frz, input int lv);
    chk({tag, ".room"}, 8'(RoomNum), 8'(room));
    chk({tag, ".logo"}, 8'(logo_en), 8'(logo));
    chk({tag, ".freeze"}, 8'(freeze), 8'(frz));
    chk({tag, ".lives"}, 8'(lives), 8'(lv));
  endtask

  // one vsync pulse: high across two Clk edges, then one quiet cycle
  task automatic frame();
    @(negedge Clk) frame_clk = 1;
    repeat (2) @(negedge Clk);
    frame_clk = 0;
    @(negedge Clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic press_start();
    @(negedge Clk) start_key = 1;
    repeat (2) @(negedge Clk);
    start_key = 0;
    @(negedge Clk);
  endtask

  task automatic event_in(input bit d, input bit c);
    @(negedge Clk) begin mario_dead = d; level_clear = c; end
    @(negedge Clk) begin mario_dead = 0; level_clear = 0; end
  endtask

  task automatic start_game();
    press_start();
    chk_out("blink0", 0, 1, 1, SL);
    frames(4);
    m_room = 1;
    m_lives = SL;
    chk_out("play_entry", 1, 0, 0, SL);
  endtask

  initial begin
    bit done, d, c;
    int n;
    repeat (3) @(negedge Clk);
    chk_out("reset", 0, 1, 1, RST_LIVES);
    Reset = 0;
    for (int i = 0; i < 10; i++) begin
      frame();
      chk_out("title_idle", 0, 1, 1, RST_LIVES);
    end
    // start latency: nothing changes one edge after the key rises
    @(negedge Clk) start_key = 1;
    @(negedge Clk) chk_out("start_lat1", 0, 1, 1, RST_LIVES);
    @(negedge Clk) chk_out("start_lat2", 0, 1, 1, SL);
    start_key = 0;
    for (int i = 1; i <= 3; i++) begin
      frame();
      chk_out($sformatf("blink%0d", i), 0, ((i / 2) % 2 == 0) ? 1 : 0, 1, SL);
    end
    @(negedge Clk) frame_clk = 1;
    @(negedge Clk) chk_out("play_lat1", 0, 0, 1, SL);
    @(negedge Clk) chk_out("play_lat2", 1, 0, 0, SL);
    frame_clk = 0;
    m_room = 1;
    m_lives = SL;
    // death wins over a simultaneous clear
    event_in(1, 1);
    chk_out("dead_clear", 1, 0, 1, SL);
    frames(2);
    chk_out("pause_hold", 1, 0, 1, SL);
    frame();
    m_lives = LV ? SL - 1 : SL;
    chk_out("respawn1", 1, 0, 0, m_lives);
    event_in(0, 1);
    chk_out("clear1", 1, 0, 1, m_lives);
    frames(3);
    chk_out("room2", 2, 0, 0, m_lives);
    event_in(0, 1);
    frames(3);
    chk_out("win_title", 0, 1, 1, m_lives);
    // two deaths from a fresh game
    start_game();
    event_in(1, 0);
    frames(3);
    chk_out("death1", 1, 0, 0, LV ? 1 : SL);
    event_in(1, 0);
    frames(3);
    if (LV) begin
      chk_out("game_over", 0, 0, 1, 0);
      frames(2);
      chk_out("game_over_hold", 0, 0, 1, 0);
      frame();
      chk_out("go_title", 0, 1, 1, 0);
    end else begin
      chk_out("death2", 1, 0, 0, SL);
      event_in(0, 1);
      frames(3);
      event_in(0, 1);
      frames(3);
      chk_out("nolives_title", 0, 1, 1, SL);
    end
    // randomized games
    for (int g = 0; g < 6; g++) begin
      start_game();
      done = 0;
      n = 0;
      while (!done) begin
        n++;
        repeat ($urandom_range(0, 4)) @(negedge Clk);
        if ($urandom_range(0, 3) == 0) begin
          press_start();
          chk_out("ignored_start", m_room, 0, 0, m_lives);
        end
        d = (n < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
        c = (n < 15) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!d && !c) c = 1;
        event_in(d, c);
        chk_out("rand_event", m_room, 0, 1, m_lives);
        mario_dead = 1'($urandom_range(0, 1));
        level_clear = 1'($urandom_range(0, 1));
        frames(2);
        mario_dead = 0;
        level_clear = 0;
        chk_out("rand_pause", m_room, 0, 1, m_lives);
        frame();
        if (d) begin
          if (LV && m_lives == 1) begin
            m_lives = 0;
            chk_out("rand_gameover", 0, 0, 1, 0);
            frames(3);
            chk_out("rand_go_title", 0, 1, 1, 0);
            done = 1;
          end else begin
            if (LV) m_lives--;
            chk_out("rand_respawn", m_room, 0, 0, m_lives);
          end
        end else if (m_room == 2) begin
          chk_out("rand_win", 0, 1, 1, m_lives);
          done = 1;
        end else begin
          m_room++;
          chk_out("rand_next", m_room, 0, 0, m_lives);
        end
      end
    end
    // reset during CLEAR_PAUSE in room 2 with start held through release
    start_game();
    event_in(0, 1);
    frames(3);
    chk_out("pre_reset_room2", 2, 0, 0, SL);
    event_in(0, 1);
    frame();
    @(negedge Clk) begin Reset = 1; start_key = 1; end
    @(negedge Clk) chk_out("reset_mid", 0, 1, 1, RST_LIVES);
    Reset = 0;
    repeat (6) @(negedge Clk);
    frames(5);
    chk_out("held_start", 0, 1, 1, RST_LIVES);
    start_key = 0;
    start_game();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
